// File: rtl/fp2int_pool_sched_if.sv
// Stream and per-lane HLS handshake bundle between the scheduler and its surroundings.
// Lane i of the packed lane buses sits at [i*DATA_W +: DATA_W].
interface fp2int_pool_sched_if #(
    parameter int NUM_LANES = 3,
    parameter int DATA_W    = 32
);
    logic                        s_valid;
    logic                        s_ready;
    logic [DATA_W-1:0]           s_data;
    logic                        m_valid;
    logic                        m_ready;
    logic [DATA_W-1:0]           m_data;
    logic [NUM_LANES-1:0]        ap_start;
    logic [NUM_LANES-1:0]        ap_ready;
    logic [NUM_LANES-1:0]        ap_done;
    logic [NUM_LANES*DATA_W-1:0] lane_in;
    logic [NUM_LANES*DATA_W-1:0] lane_out;

    modport slave (
        input  s_valid, s_data, m_ready, ap_ready, ap_done, lane_out,
        output s_ready, m_valid, m_data, ap_start, lane_in
    );

    modport master (
        output s_valid, s_data, m_ready, ap_ready, ap_done, lane_out,
        input  s_ready, m_valid, m_data, ap_start, lane_in
    );
endinterface

// File: rtl/fp2int_pool_sched.sv
// Round-robin scheduler over a pool of ap_ctrl_hs fp2int cores; results leave in arrival order.
// Dispatch and retire pointers walk the lanes in the same order, so no reorder buffer is needed.
module fp2int_pool_sched #(
    parameter  int NUM_LANES = 3,
    parameter  int DATA_W    = 32,
    localparam int PW        = $clog2(NUM_LANES),
    localparam int IW        = $clog2(NUM_LANES + 1)
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    fp2int_pool_sched_if.slave      io_bus,
    input  logic                    i_err_clr,
    output logic [IW-1:0]           o_inflight,
    output logic                    o_err_sticky
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_FULL} lane_st_t;

    logic                 w_accept;
    logic                 w_retire;
    logic [NUM_LANES-1:0] w_acc_lane;
    logic [NUM_LANES-1:0] w_ret_lane;
    logic [NUM_LANES-1:0] w_is_idle;
    logic [NUM_LANES-1:0] w_is_full;
    logic [NUM_LANES-1:0] w_spur;
    logic [DATA_W-1:0]    w_results [NUM_LANES];

    logic                 r_run;
    logic [PW-1:0]        r_disp_ptr;
    logic [PW-1:0]        r_ret_ptr;
    logic [IW-1:0]        r_inflight;
    logic                 r_err;

    // r_run keeps s_ready low throughout reset even though every lane resets to IDLE.
    assign io_bus.s_ready = r_run && w_is_idle[r_disp_ptr];
    assign io_bus.m_valid = w_is_full[r_ret_ptr];
    assign io_bus.m_data  = w_results[r_ret_ptr];
    assign w_accept       = io_bus.s_valid && io_bus.s_ready;
    assign w_retire       = io_bus.m_valid && io_bus.m_ready;
    assign o_inflight     = r_inflight;
    assign o_err_sticky   = r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            lane_st_t          r_state;
            lane_st_t          w_state_next;
            logic              w_capture;
            logic [DATA_W-1:0] r_result;
            logic [DATA_W-1:0] r_operand;

            assign w_acc_lane[gi] = w_accept && (r_disp_ptr == PW'(gi));
            assign w_ret_lane[gi] = w_retire && (r_ret_ptr == PW'(gi));

            always_comb begin
                w_state_next = r_state;
                w_capture    = 1'b0;
                w_spur[gi]   = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        w_spur[gi] = io_bus.ap_done[gi];
                        if (w_acc_lane[gi]) w_state_next = ST_START;
                    end
                    ST_START: begin
                        // A zero-latency core reports ready and done together: skip WAIT.
                        if (io_bus.ap_done[gi]) begin
                            w_capture    = 1'b1;
                            w_state_next = ST_FULL;
                        end else if (io_bus.ap_ready[gi]) begin
                            w_state_next = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (io_bus.ap_done[gi]) begin
                            w_capture    = 1'b1;
                            w_state_next = ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        w_spur[gi] = io_bus.ap_done[gi];
                        if (w_ret_lane[gi]) w_state_next = ST_IDLE;
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    r_state   <= ST_IDLE;
                    r_result  <= '0;
                    r_operand <= '0;
                end else begin
                    r_state <= w_state_next;
                    if (w_acc_lane[gi]) r_operand <= io_bus.s_data;
                    if (w_capture)      r_result  <= io_bus.lane_out[gi*DATA_W +: DATA_W];
                end
            end

            assign io_bus.ap_start[gi]                  = (r_state == ST_START);
            assign io_bus.lane_in[gi*DATA_W +: DATA_W]  = r_operand;
            assign w_is_idle[gi]                        = (r_state == ST_IDLE);
            assign w_is_full[gi]                        = (r_state == ST_FULL);
            assign w_results[gi]                        = r_result;
        end
    endgenerate

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_run      <= 1'b0;
            r_disp_ptr <= '0;
            r_ret_ptr  <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept)
                r_disp_ptr <= (r_disp_ptr == PW'(NUM_LANES - 1)) ? '0 : r_disp_ptr + PW'(1);
            if (w_retire)
                r_ret_ptr <= (r_ret_ptr == PW'(NUM_LANES - 1)) ? '0 : r_ret_ptr + PW'(1);
            case ({w_accept, w_retire})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: r_inflight <= r_inflight;
            endcase
            // A fresh unexpected ap_done outranks a clear in the same cycle.
            if (|w_spur)        r_err <= 1'b1;
            else if (i_err_clr) r_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp2int_pool_sched.sv
// Directed bench: behavioural fp2int cores on every lane, a feed queue and an in-order scoreboard.
// All driving and sampling happens on the falling clock edge.
module tb_fp2int_pool_sched;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int IW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          err_clr;
    logic [IW-1:0] inflight;
    logic          err_sticky;

    always #5 clk = ~clk;

    fp2int_pool_sched_if #(.NUM_LANES(N), .DATA_W(W)) bus ();

    fp2int_pool_sched #(.NUM_LANES(N), .DATA_W(W)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rstn),
        .io_bus        (bus.slave),
        .i_err_clr     (err_clr),
        .o_inflight    (inflight),
        .o_err_sticky  (err_sticky)
    );

    int           total = 0;
    int           bad   = 0;
    int           lat   [N];
    bit           busy  [N];
    int           cnt   [N];
    logic [W-1:0] res   [N];
    logic [N-1:0] spur_mask = '0;
    logic [W-1:0] feed_fp  [$];
    logic [W-1:0] feed_exp [$];
    logic [W-1:0] exp_q    [$];
    int           acc_cnt = 0;
    int           ret_cnt = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Behavioural model of the external HLS core: truncating FP32 to int conversion.
    function automatic logic [W-1:0] fp2int(input logic [31:0] f);
        int          e;
        logic [63:0] m;
        logic [31:0] r;
        e = int'(f[30:23]);
        m = {40'd0, 1'b1, f[22:0]};
        if (e < 127)       r = '0;
        else if (e >= 150) r = 32'(m << (e - 150));
        else               r = 32'(m >> (150 - e));
        if (f[31]) r = -r;
        return r;
    endfunction

    task automatic push(input logic [W-1:0] fp, input logic [W-1:0] iv);
        feed_fp.push_back(fp);
        feed_exp.push_back(iv);
    endtask

    // One cycle: drive cores and feed, score handshakes, advance to the next falling edge.
    task automatic tick();
        logic [N-1:0] rdy;
        logic [N-1:0] dn;
        rdy = '0;
        dn  = '0;
        for (int i = 0; i < N; i++) begin
            if (busy[i]) begin
                if (cnt[i] == 0) begin
                    dn[i]   = 1'b1;
                    busy[i] = 1'b0;
                end else begin
                    cnt[i]--;
                end
            end else if (bus.ap_start[i]) begin
                rdy[i] = 1'b1;
                res[i] = fp2int(bus.lane_in[i*W +: W]);
                if (lat[i] == 0) dn[i] = 1'b1;
                else begin
                    busy[i] = 1'b1;
                    cnt[i]  = lat[i] - 1;
                end
            end
            if (dn[i]) bus.lane_out[i*W +: W] = res[i];
        end
        bus.ap_ready = rdy;
        bus.ap_done  = dn | spur_mask;
        spur_mask    = '0;
        bus.s_valid  = (feed_fp.size() > 0);
        bus.s_data   = (feed_fp.size() > 0) ? feed_fp[0] : '0;
        if (bus.s_valid && bus.s_ready) begin
            $display("accept fp=%h", bus.s_data);
            exp_q.push_back(feed_exp.pop_front());
            void'(feed_fp.pop_front());
            acc_cnt++;
        end
        if (bus.m_valid && bus.m_ready) begin
            $display("retire data=%0d", bus.m_data);
            if (exp_q.size() == 0) chk("unexpected_result", bus.m_data, 'x);
            else                   chk("m_data_order", bus.m_data, exp_q.pop_front());
            ret_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic wait_acc(input string tag, input int target);
        int n = 0;
        while (acc_cnt < target && n < 60) begin
            tick();
            n++;
        end
        chk(tag, acc_cnt, target);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() + feed_fp.size()) > 0 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size() + feed_fp.size(), 0);
    endtask

    initial begin
        int n;
        int r0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b0;
        bus.ap_ready = '0;
        bus.ap_done  = '0;
        bus.lane_out = '0;
        err_clr      = 1'b0;
        for (int i = 0; i < N; i++) begin
            lat[i] = 3; busy[i] = 1'b0; cnt[i] = 0; res[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_s_ready",  bus.s_ready, 0);
        chk("rst_m_valid",  bus.m_valid, 0);
        chk("rst_ap_start", bus.ap_start, 0);
        chk("rst_lane_in",  bus.lane_in[W-1:0], 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err",      err_sticky, 0);
        rstn = 1'b1;
        tick();

        // 1: single pi through a latency-3 core
        bus.m_ready = 1'b1;
        push(32'h40490FDB, 32'd3);
        wait_acc("t1_accept", 1);
        chk("t1_ap_start", bus.ap_start, 3'b001);
        chk("t1_inflight", inflight, 1);
        n = 0;
        while (!bus.m_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t1_latency", n, 4);
        chk("t1_m_data", bus.m_data, 32'd3);
        tick();
        chk("t1_inflight_end", inflight, 0);

        // 2: twelve words, mixed lane latencies, pointers wrap four times
        lat[0] = 5; lat[1] = 2; lat[2] = 3;
        r0 = ret_cnt;
        push(32'h3F800000, 1);  push(32'h40000000, 2);  push(32'h40400000, 3);
        push(32'h40800000, 4);  push(32'h40A00000, 5);  push(32'h40C00000, 6);
        push(32'h40E00000, 7);  push(32'h41000000, 8);  push(32'h41100000, 9);
        push(32'h41200000, 10); push(32'h41300000, 11); push(32'h41400000, 12);
        drain("t2_drain");
        chk("t2_count", ret_cnt - r0, 12);
        repeat (2) tick();
        chk("t2_inflight", inflight, 0);

        // 3: backpressure for 20 cycles
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        bus.m_ready = 1'b0;
        r0 = ret_cnt;
        push(32'h41500000, 13); push(32'h41600000, 14); push(32'h41700000, 15);
        push(32'h41800000, 16); push(32'h41880000, 17); push(32'h41900000, 18);
        repeat (10) tick();
        chk("t3_m_data_mid", bus.m_data, 32'd13);
        repeat (10) tick();
        chk("t3_s_ready", bus.s_ready, 0);
        chk("t3_inflight", inflight, 3);
        chk("t3_m_valid", bus.m_valid, 1);
        chk("t3_m_data_held", bus.m_data, 32'd13);
        chk("t3_pending", feed_fp.size(), 3);
        bus.m_ready = 1'b1;
        drain("t3_drain");
        chk("t3_count", ret_cnt - r0, 6);

        // 4: ready and done together on every lane
        lat[0] = 0; lat[1] = 0; lat[2] = 0;
        r0 = ret_cnt;
        push(32'h40A00000, 5); push(32'h40C00000, 6); push(32'h40E00000, 7);
        push(32'h41000000, 8);
        drain("t4_drain");
        chk("t4_count", ret_cnt - r0, 4);
        chk("t4_err", err_sticky, 0);

        // 5: spurious ap_done on idle lane 1, then clear
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        repeat (3) tick();
        spur_mask = 3'b010;
        tick();
        chk("t5_err_set", err_sticky, 1);
        r0 = ret_cnt;
        push(32'h41100000, 9); push(32'h41200000, 10);
        drain("t5_drain");
        chk("t5_count", ret_cnt - r0, 2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_err_clr", err_sticky, 0);

        // 6: reset with two jobs in flight, stale ap_done afterwards
        lat[0] = 10; lat[1] = 10; lat[2] = 10;
        push(32'h3F800000, 1); push(32'h40000000, 2);
        bus.m_ready = 1'b0;
        wait_acc("t6_accept", acc_cnt + 2);
        chk("t6_inflight_pre", inflight, 2);
        rstn = 1'b0;
        #1;
        chk("t6_ap_start", bus.ap_start, 0);
        chk("t6_m_valid", bus.m_valid, 0);
        chk("t6_inflight", inflight, 0);
        chk("t6_s_ready", bus.s_ready, 0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        while (!err_sticky && n < 30) begin
            tick();
            n++;
        end
        chk("t6_stale_err", err_sticky, 1);
        n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 30) begin
            tick();
            n++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        bus.m_ready = 1'b1;
        lat[0] = 1;
        push(32'h40400000, 3);
        wait_acc("t6_new_accept", acc_cnt + 1);
        chk("t6_lane0", bus.ap_start, 3'b001);
        drain("t6_drain");
        chk("t6_err_final", err_sticky, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
